// File: rtl/cond_flag_unit.sv
// cond_flag_unit: holds the architectural NZCV flags and evaluates each
// instruction's condition field against them. Write controls are gated so that
// an instruction whose condition fails has no side effects. A saturating
// counter records how many valid instructions failed their condition.
//
// Timing: the condition check uses only the stored flags, never ALUFlags, so a
// flag update reaches the instruction in the following cycle.
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             ClearCount,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] CondFailCount
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cond_pass;
  logic             cond_ex;
  logic             flag_n, flag_z, flag_c, flag_v;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Decode the condition field against the stored flags.
  always_comb begin
    cond_pass = 1'b1;
    unique case (Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b1;  // 1111 behaves as unconditional
    endcase
  end

  // Reset masks execution so the gated outputs drop without waiting for clk.
  assign cond_ex  = InstrValid & cond_pass & ~reset;

  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & ~NoWrite & cond_ex;
  assign MemWrite = MemW & cond_ex;

  assign Flags         = flags_q;
  assign CondFailCount = cnt_q;

  // Next flag value: each half updates independently, only for executed instructions.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Next fail count: clear has priority, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (ClearCount) begin
      cnt_d = '0;
    end else if (InstrValid && !cond_pass && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: a table of condition vectors plus
// hand-written sequences for flag latency, half updates, saturation and reset.
module tb_cond_flag_unit;

  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             InstrValid, PCS, RegW, MemW, NoWrite, ClearCount;
  logic [3:0]       Cond, ALUFlags;
  logic [1:0]       FlagW;
  logic             PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] CondFailCount;

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .ClearCount(ClearCount), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .CondFailCount(CondFailCount)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    InstrValid = 1'b0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    ClearCount = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
  endtask

  // Load the flag register with an unconditional full flag write.
  task automatic load_flags(input logic [3:0] f);
    idle();
    InstrValid = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    idle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] flags;  // stored flags before the vector (NZCV)
    logic [3:0] cond;
    logic [4:0] ins;    // {InstrValid, PCS, RegW, MemW, NoWrite}
    logic [3:0] exp;    // {CondEx, PCSrc, RegWrite, MemWrite}
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 5'b10100, 4'b1010}; // EQ, Z=1
    vecs[1]  = '{4'b0100, 4'b0001, 5'b10100, 4'b0000}; // NE fails
    vecs[2]  = '{4'b0010, 4'b0010, 5'b11000, 4'b1100}; // CS
    vecs[3]  = '{4'b0010, 4'b0011, 5'b11000, 4'b0000}; // CC fails
    vecs[4]  = '{4'b1000, 4'b0100, 5'b10010, 4'b1001}; // MI
    vecs[5]  = '{4'b1000, 4'b0101, 5'b10010, 4'b0000}; // PL fails
    vecs[6]  = '{4'b0001, 4'b0110, 5'b11110, 4'b1111}; // VS
    vecs[7]  = '{4'b0001, 4'b0111, 5'b11110, 4'b0000}; // VC fails
    vecs[8]  = '{4'b0010, 4'b1000, 5'b10100, 4'b1010}; // HI C&~Z
    vecs[9]  = '{4'b0110, 4'b1000, 5'b10100, 4'b0000}; // HI fails on Z
    vecs[10] = '{4'b0110, 4'b1001, 5'b10010, 4'b1001}; // LS
    vecs[11] = '{4'b1001, 4'b1010, 5'b10010, 4'b1001}; // GE N==V
    vecs[12] = '{4'b1001, 4'b1011, 5'b10010, 4'b0000}; // LT fails
    vecs[13] = '{4'b1001, 4'b1100, 5'b10000, 4'b1000}; // GT
    vecs[14] = '{4'b1101, 4'b1100, 5'b10100, 4'b0000}; // GT fails on Z
    vecs[15] = '{4'b1101, 4'b1101, 5'b10100, 4'b1010}; // LE via Z
    vecs[16] = '{4'b1000, 4'b1101, 5'b11000, 4'b1100}; // LE via N!=V
    vecs[17] = '{4'b0000, 4'b1110, 5'b10101, 4'b1000}; // AL, NoWrite
    vecs[18] = '{4'b0000, 4'b1111, 5'b11110, 4'b1111}; // 1111 unconditional
    vecs[19] = '{4'b0100, 4'b0001, 5'b01110, 4'b0000}; // bubble, would fail
    vecs[20] = '{4'b0100, 4'b0000, 5'b01110, 4'b0000}; // bubble, would pass
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    reset = 1'b1;
    exp_cnt = '0;
    #12;
    // Reset holds outputs low even with an executable instruction present.
    InstrValid = 1'b1; Cond = 4'b1110; RegW = 1'b1;
    #1;
    check("rst_regwrite", RegWrite, 0);
    check("rst_condex", CondEx, 0);
    check("rst_flags", Flags, 4'b0000);
    check("rst_count", CondFailCount, 0);
    reset = 1'b0;
    #1;
    check("post_rst_regwrite", RegWrite, 1);
    idle();
    step();

    // One-cycle flag latency: EQ in the same cycle as Z is written uses old flags.
    InstrValid = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    check("lat_flags", Flags, 4'b0100);
    FlagW = 2'b00; Cond = 4'b0000; RegW = 1'b1;
    #1;
    check("lat_eq_regwrite", RegWrite, 1);
    Cond = 4'b0001;
    #1;
    check("lat_ne_regwrite", RegWrite, 0);
    step();
    exp_cnt++;
    check("lat_ne_count", CondFailCount, exp_cnt);
    idle();

    // Independent half updates.
    load_flags(4'b0000);
    InstrValid = 1'b1; Cond = 4'b1110; ALUFlags = 4'b1011; FlagW = 2'b10;
    step();
    check("half_nz", Flags, 4'b1000);
    ALUFlags = 4'b0011; FlagW = 2'b01;
    step();
    check("half_cv", Flags, 4'b1011);
    idle();

    // Failed conditional compare leaves flags alone; bubble does not count.
    load_flags(4'b0000);
    InstrValid = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
    step();
    exp_cnt++;
    check("failcmp_flags", Flags, 4'b0000);
    check("failcmp_count", CondFailCount, exp_cnt);
    InstrValid = 1'b0;
    step();
    check("bubble_flags", Flags, 4'b0000);
    check("bubble_count", CondFailCount, exp_cnt);
    idle();

    // Table-driven condition vectors.
    for (int i = 0; i < NV; i++) begin
      load_flags(vecs[i].flags);
      check($sformatf("v%0d_flags_in", i), Flags, vecs[i].flags);
      {InstrValid, PCS, RegW, MemW, NoWrite} = vecs[i].ins;
      Cond = vecs[i].cond;
      #1;
      check($sformatf("v%0d_condex", i), CondEx, vecs[i].exp[3]);
      check($sformatf("v%0d_pcsrc", i), PCSrc, vecs[i].exp[2]);
      check($sformatf("v%0d_regwrite", i), RegWrite, vecs[i].exp[1]);
      check($sformatf("v%0d_memwrite", i), MemWrite, vecs[i].exp[0]);
      if (vecs[i].ins[4] && !vecs[i].exp[3]) exp_cnt++;
      step();
      check($sformatf("v%0d_count", i), CondFailCount, exp_cnt);
      check($sformatf("v%0d_flags_out", i), Flags, vecs[i].flags);
      idle();
    end

    // Clear, then drive the counter to saturation.
    ClearCount = 1'b1;
    step();
    exp_cnt = '0;
    check("clear_count", CondFailCount, exp_cnt);
    load_flags(4'b0000);
    InstrValid = 1'b1; Cond = 4'b0000;
    for (int i = 0; i < 65535; i++) step();
    exp_cnt = 16'hFFFF;
    check("sat_reach", CondFailCount, exp_cnt);
    step();
    step();
    check("sat_hold", CondFailCount, exp_cnt);
    ClearCount = 1'b1;
    step();
    exp_cnt = '0;
    check("clear_beats_inc", CondFailCount, exp_cnt);
    ClearCount = 1'b0;
    step();
    exp_cnt++;
    check("inc_after_clear", CondFailCount, exp_cnt);
    idle();

    // Reset asserted between edges.
    load_flags(4'b1111);
    InstrValid = 1'b1; Cond = 4'b0100; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    FlagW = 2'b11; ALUFlags = 4'b0110;
    #1;
    check("mid_pre_pcsrc", PCSrc, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_pcsrc", PCSrc, 0);
    check("mid_regwrite", RegWrite, 0);
    check("mid_memwrite", MemWrite, 0);
    check("mid_flags", Flags, 4'b0000);
    check("mid_count", CondFailCount, 0);
    step();
    check("mid_edge_flags", Flags, 4'b0000);
    idle();
    #2;
    reset = 1'b0;
    step();
    check("post_mid_flags", Flags, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Sits directly downstream of the ALU.
- Captures the ALU's 4-bit NZCV flag vector into an architectural flag register and evaluates each instruction's 4-bit condition field against the stored flags.
- Gates the processor's register-write, memory-write and PC-source controls so that condition-failed instructions have no side effects.
- Keeps a saturating count of condition-failed instructions for debug.

Parameters:
- CNT_W, 16, width of the condition-failed instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- InstrValid  input  1  current-cycle instruction is real; 0 marks a bubble or stall.
- Cond  input  4  instruction condition field.
- ALUFlags  input  4  ALU flags from the current instruction: [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  input  2  [1] requests an N,Z update; [0] requests a C,V update.
- PCS  input  1  decoder requests a PC write.
- RegW  input  1  decoder requests a register-file write.
- MemW  input  1  decoder requests a memory write.
- NoWrite  input  1  compare-type instruction; suppresses the register write.
- ClearCount  input  1  synchronous clear of the fail counter.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  stored NZCV register, same bit order as ALUFlags.
- CondFailCount  output  CNT_W  number of valid instructions whose condition failed.

Behaviour:

Reset:
- Flags and CondFailCount go to 0 immediately on reset assertion, without waiting for clk.
- While reset is high, PCSrc, RegWrite and MemWrite are forced to 0, CondEx reads 0, and no state updates.

Condition evaluation:
- Purely combinational from Cond and the stored Flags, never from ALUFlags. An instruction's own flag update is therefore visible to the next instruction only (one-cycle latency).
- Codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: treated as 1 (unconditional).
- CondEx = InstrValid & cond_pass.

Output gating (combinational):
- PCSrc = PCS & CondEx
- RegWrite = RegW & ~NoWrite & CondEx
- MemWrite = MemW & CondEx

Flag register:
- On a rising edge with CondEx=1:
  - if FlagW[1]=1, Flags[3:2] <= ALUFlags[3:2];
  - if FlagW[0]=1, Flags[1:0] <= ALUFlags[1:0].
- Each half updates independently; a half whose FlagW bit is 0 holds.
- No update when InstrValid=0 or the condition fails, including a conditional compare whose condition fails.

Fail counter:
- On a rising edge, if ClearCount=1, the counter goes to 0. Clear wins over a simultaneous increment.
- Otherwise, if InstrValid=1 and cond_pass=0, the counter increments by 1.
- The counter saturates at all-ones and never wraps.

Reset mid-operation:
- Asserting reset between edges drops all gated outputs to 0 in the same cycle.
- Any flag update pending for the next edge is discarded.

Test Plan:
- Reset, then Cond=1110, RegW=1, InstrValid=1 -> RegWrite=1, Flags=0000, CondFailCount=0.
- Cycle 1: ALUFlags=0100, FlagW=11, Cond=1110. Cycle 2: Cond=0000 (EQ), RegW=1 -> cycle 2 RegWrite=1. Same cycle 2 with Cond=0001 (NE) -> RegWrite=0 and CondFailCount=1.
- Flags=0000; Cond=1110, ALUFlags=1011, FlagW=10 -> next Flags=1000 (C,V held at 0). Then FlagW=01, ALUFlags=0011 -> Flags=1011.
- Flags=1001 (N=1,V=1), Cond=1010 (GE), MemW=1 -> MemWrite=1. Cond=1011 (LT) -> MemWrite=0. Cond=1100 (GT) -> CondEx=1.
- Flags=0000, Cond=0000 (fails), FlagW=11, ALUFlags=1111 -> Flags stays 0000, CondFailCount+1. Same stimulus with InstrValid=0 -> no count increment.
- Force CondFailCount to 0xFFFF via repeated fails -> stays 0xFFFF. ClearCount=1 together with a failing instruction -> 0. Assert reset between edges -> PCSrc/RegWrite/MemWrite drop to 0 immediately and Flags=0000.
